// File: rtl/prog_loader_rx_pkg.sv
// Shared types and constants for the UART program loader.
// Holds receiver/loader state enums and line geometry constants.
package prog_loader_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      HDR,
      LOAD,
      DONE
   } ld_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORDS_PER_LINE = 4;
   localparam int LINE_BITS      = 128;

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver with 2-flop input synchronizer.
// Ports: clk, reset_x (async low), rxd in; byte_out, byte_valid, frame_err out.
module uart_rx_byte
   import prog_loader_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset_x,
   input  logic       rxd,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic            sync1;
   logic            rxd_s;
   rx_state_t       state;
   rx_state_t       state_d;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_d;
   logic [2:0]      bit_cnt;
   logic [2:0]      bit_d;
   logic [7:0]      shreg;
   logic [7:0]      sh_d;
   logic            valid_d;
   logic            ferr_d;

   // Idle-high reset values keep a reset release from looking like a start bit.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         sync1 <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxd_s <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         bit_cnt    <= bit_d;
         shreg      <= sh_d;
         byte_valid <= valid_d;
         frame_err  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt + 1'b1;
      bit_d   = bit_cnt;
      sh_d    = shreg;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!rxd_s) state_d = START;
         end
         START: begin
            // Mid-bit recheck rejects short glitches.
            if (cnt == HALF) begin
               cnt_d   = '0;
               state_d = rxd_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL) begin
               cnt_d = '0;
               sh_d  = {rxd_s, shreg[7:1]};
               bit_d = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt == FULL) begin
               cnt_d   = '0;
               state_d = IDLE;
               valid_d = rxd_s;
               ferr_d  = !rxd_s;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign byte_out = shreg;

endmodule

// File: rtl/prog_loader_rx.sv
// UART program loader: 32-bit LE line count header, then 16*L bytes.
// Ports: clk, reset_x, rxd in; addr, data, we_32, we_128, done, err out.
module prog_loader_rx
   import prog_loader_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 reset_x,
   input  logic                 rxd,
   output logic [31:0]          addr,
   output logic [LINE_BITS-1:0] data,
   output logic                 we_32,
   output logic                 we_128,
   output logic                 done,
   output logic                 err
);

   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        rx_ferr;

   ld_state_t   state;
   ld_state_t   state_d;
   logic [1:0]  byte_cnt;
   logic [31:0] asm_q;
   logic [31:0] word;
   logic [31:0] len;
   logic [31:0] word_index;
   logic [31:0] line_cnt;
   logic        word_last;
   logic        line_end;
   logic        last_line;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .reset_x   (reset_x),
      .rxd       (rxd),
      .byte_out  (rx_byte),
      .byte_valid(rx_valid),
      .frame_err (rx_ferr)
   );

   // Bytes arrive LSB first, so each new byte enters at the top.
   assign word      = {rx_byte, asm_q[31:8]};
   assign word_last = rx_valid &&
                      (byte_cnt == 2'(BYTES_PER_WORD - 1));
   assign line_end  = (word_index[1:0] == 2'(WORDS_PER_LINE - 1));
   assign last_line = (line_cnt == len - 32'd1);

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) state <= HDR;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         HDR: begin
            if (word_last)
               state_d = (word == 32'd0) ? DONE : LOAD;
         end
         LOAD: begin
            if (word_last && line_end && last_line)
               state_d = DONE;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = HDR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         byte_cnt   <= '0;
         asm_q      <= '0;
         len        <= '0;
         word_index <= '0;
         line_cnt   <= '0;
         addr       <= '0;
         data       <= '0;
         we_32      <= 1'b0;
         we_128     <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         we_32  <= 1'b0;
         we_128 <= 1'b0;
         err    <= err | rx_ferr;
         // One cycle behind the state so it trails the final strobe.
         done   <= done | (state == DONE);
         if (rx_valid && state != DONE) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= word;
            if (state == HDR && word_last)
               len <= word;
            if (state == LOAD && word_last) begin
               data       <= {word, data[LINE_BITS-1:32]};
               addr       <= {word_index[29:0], 2'b00};
               word_index <= word_index + 32'd1;
               we_32      <= 1'b1;
               we_128     <= line_end;
               if (line_end)
                  line_cnt <= line_cnt + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_prog_loader_rx.sv
// Scoreboard bench for prog_loader_rx at CLKS_PER_BIT=16.
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
module tb_prog_loader_rx;

   localparam int CPB = 16;

   logic         clk = 1'b0;
   logic         reset_x = 1'b0;
   logic         rxd = 1'b1;
   logic [31:0]  addr;
   logic [127:0] data;
   logic         we_32;
   logic         we_128;
   logic         done;
   logic         err;

   typedef struct {
      logic [31:0]  addr;
      logic [31:0]  word;
      bit           line;
      bit           last;
      logic [127:0] ldata;
   } exp_t;

   exp_t sb[$];
   int   n_err = 0;
   int   n_chk = 0;
   bit   prev_strobe = 1'b0;
   bit   done_next = 1'b0;

   localparam logic [127:0] LINE_A =
      128'h002081B3_00200113_00100093_00000013;
   localparam logic [127:0] LINE_B =
      128'hDDEEFF00_99AABBCC_55667788_11223344;
   localparam logic [127:0] LINE_C =
      128'h0000006F_FE010113_00812623_01010413;
   localparam logic [127:0] LINE_D =
      128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;

   prog_loader_rx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk    (clk),
      .reset_x(reset_x),
      .rxd    (rxd),
      .addr   (addr),
      .data   (data),
      .we_32  (we_32),
      .we_128 (we_128),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done_next) begin
         chk("done_rise", 128'(done), 128'd1);
         done_next = 1'b0;
      end
      if (we_32 || we_128) begin
         chk("no_back_to_back", 128'(prev_strobe), 128'd0);
         if (sb.size() == 0) begin
            chk("unexpected_strobe", 128'(addr), 128'hFFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("we_32", 128'(we_32), 128'd1);
            chk("we_128", 128'(we_128), 128'(e.line));
            chk("addr", 128'(addr), 128'(e.addr));
            chk("word", 128'(data[127:96]), 128'(e.word));
            if (e.line) chk("line_data", data, e.ldata);
            if (e.last) begin
               chk("done_at_strobe", 128'(done), 128'd0);
               done_next = 1'b1;
            end
         end
      end
      prev_strobe = we_32 || we_128;
   end

   task automatic send_byte(input logic [7:0] b, input bit good);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = good;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic send_w(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic send_word(input logic [31:0] w,
                            input int idx,
                            input bit line,
                            input bit last,
                            input logic [127:0] ld);
      exp_t e;
      e.addr  = 32'(idx) << 2;
      e.word  = w;
      e.line  = line;
      e.last  = last;
      e.ldata = ld;
      sb.push_back(e);
      send_w(w);
   endtask

   task automatic send_line(input logic [127:0] ld,
                            input int base,
                            input bit last);
      for (int k = 0; k < 4; k++)
         send_word(ld[32*k +: 32], base + k, k == 3,
                   last && (k == 3), ld);
   endtask

   task automatic pulse_reset(input bit check);
      #2 reset_x = 1'b0;
      rxd = 1'b1;
      #1;
      if (check) begin
         chk("rst_addr", 128'(addr), 128'd0);
         chk("rst_data", data, 128'd0);
         chk("rst_we32", 128'(we_32), 128'd0);
         chk("rst_we128", 128'(we_128), 128'd0);
         chk("rst_done", 128'(done), 128'd0);
         chk("rst_err", 128'(err), 128'd0);
      end
      repeat (3) @(negedge clk);
      reset_x = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic settle(input string nm);
      repeat (4) @(negedge clk);
      chk(nm, 128'(sb.size()), 128'd0);
      sb.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      reset_x = 1'b0;
      repeat (4) @(negedge clk);
      chk("init_addr", 128'(addr), 128'd0);
      chk("init_data", data, 128'd0);
      chk("init_we", 128'({we_32, we_128}), 128'd0);
      chk("init_flags", 128'({done, err}), 128'd0);
      reset_x = 1'b1;
      repeat (3) @(negedge clk);

      // L=1 basic load
      send_w(32'd1);
      send_line(LINE_A, 0, 1'b1);
      settle("s1_drain");
      chk("s1_done", 128'(done), 128'd1);
      chk("s1_err", 128'(err), 128'd0);

      // Bytes after done are ignored
      for (int i = 0; i < 8; i++) send_byte(8'(8'h5A + i), 1'b1);
      settle("s2_drain");
      chk("s2_addr", 128'(addr), 128'd12);
      chk("s2_data", data, LINE_A);
      chk("s2_done", 128'(done), 128'd1);

      // L=0: done with no strobes
      pulse_reset(1'b0);
      send_w(32'd0);
      settle("s3_drain");
      chk("s3_done", 128'(done), 128'd1);
      chk("s3_addr", 128'(addr), 128'd0);
      chk("s3_data", data, 128'd0);

      // Framing error on header byte 2, then resent
      pulse_reset(1'b0);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hA5, 1'b0);
      chk("s4_err", 128'(err), 128'd1);
      chk("s4_not_done", 128'(done), 128'd0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_line(LINE_B, 0, 1'b1);
      settle("s4_drain");
      chk("s4_done", 128'(done), 128'd1);
      chk("s4_err_sticky", 128'(err), 128'd1);
      chk("s4_data", data, LINE_B);

      // Idle glitch must not create a byte
      pulse_reset(1'b0);
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("s5_err", 128'(err), 128'd0);
      chk("s5_done", 128'(done), 128'd0);
      send_w(32'd1);
      send_line(LINE_C, 0, 1'b1);
      settle("s5_drain");
      chk("s5_done_after", 128'(done), 128'd1);
      chk("s5_addr", 128'(addr), 128'd12);

      // Reset mid-line 2 of L=3, mid-byte
      pulse_reset(1'b0);
      send_w(32'd3);
      send_line(LINE_D, 0, 1'b0);
      send_word(32'hCAFEF00D, 4, 1'b0, 1'b0, 128'd0);
      send_word(32'h0BADBEEF, 5, 1'b0, 1'b0, 128'd0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      settle("s6_pre_drain");
      chk("s6_pre_addr", 128'(addr), 128'd20);
      rxd = 1'b0;
      repeat (2 * CPB + 8) @(negedge clk);
      pulse_reset(1'b1);
      send_w(32'd1);
      send_line(LINE_A, 0, 1'b1);
      settle("s6_drain");
      chk("s6_done", 128'(done), 128'd1);
      chk("s6_addr", 128'(addr), 128'd12);
      chk("s6_data", data, LINE_A);
      chk("s6_err", 128'(err), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
